// File: rtl/mem_stage_if.sv
// Data-memory port between the MEM stage and the data memory.
// The MEM stage is the master: it drives the request, address, write data
// and byte enables. The memory is the slave: it answers with ready and the
// read word.
interface mem_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ready;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ready, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ready, rdata
  );
endinterface

// File: rtl/mem_stage.sv
// MIPS memory-access stage sitting between EX/MEM and MEM/WB.
// It issues data-memory accesses over a req/ready handshake. It formats
// store lanes and load data for byte, half and word accesses. While memory
// is busy it stalls the front end. It flags misaligned accesses and
// timeouts, and it owns the MEM/WB pipeline register.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] ALUResult_EXMEM,
  input  logic [31:0] rtData_EXMEM,
  input  logic [4:0]  writeRegister_EXMEM,
  input  logic        MemtoReg_EXMEM,
  input  logic        RegWriteEn_EXMEM,
  input  logic        MemReadEn_EXMEM,
  input  logic        MemWriteEn_EXMEM,
  input  logic [1:0]  MemSize_EXMEM,
  input  logic        LoadUnsigned_EXMEM,
  mem_stage_if.master dmem,
  output logic        stall_mem,
  output logic [4:0]  writeRegister_MEMWB,
  output logic [31:0] WBData_MEMWB,
  output logic        RegWriteEn_MEMWB,
  output logic        misalign_err,
  output logic        bus_err
);

  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  typedef enum logic [0:0] {IDLE, WAIT} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] wait_cnt;

  logic        op;
  logic        misalign;
  logic [1:0]  lane;
  logic        size_half;
  logic        size_word;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic        req_raw;
  logic        stall_raw;
  logic        complete;
  logic        abort;
  logic        cnt_load;
  logic        cnt_inc;

  // Decode the access type and detect misalignment.
  always_comb begin
    op        = MemReadEn_EXMEM | MemWriteEn_EXMEM;
    lane      = ALUResult_EXMEM[1:0];
    size_half = (MemSize_EXMEM == 2'b01);
    size_word = MemSize_EXMEM[1];
    misalign  = op & ((size_half & lane[0]) | (size_word & (lane != 2'b00)));
  end

  // Build the byte enables and replicate store data into every lane.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = rtData_EXMEM;
    case (MemSize_EXMEM)
      2'b00: begin
        lane_be    = 4'b0001 << lane;
        lane_wdata = {4{rtData_EXMEM[7:0]}};
      end
      2'b01: begin
        lane_be    = lane[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{rtData_EXMEM[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = rtData_EXMEM;
      end
    endcase
  end

  // Pick the addressed byte/half from the read word and extend it to 32 bits.
  always_comb begin
    byte_lane = dmem.rdata[7:0];
    case (lane)
      2'b00:   byte_lane = dmem.rdata[7:0];
      2'b01:   byte_lane = dmem.rdata[15:8];
      2'b10:   byte_lane = dmem.rdata[23:16];
      default: byte_lane = dmem.rdata[31:24];
    endcase
    half_lane = lane[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
    load_data = dmem.rdata;
    case (MemSize_EXMEM)
      2'b00: load_data = LoadUnsigned_EXMEM ? {24'b0, byte_lane}
                                            : {{24{byte_lane[7]}}, byte_lane};
      2'b01: load_data = LoadUnsigned_EXMEM ? {16'b0, half_lane}
                                            : {{16{half_lane[15]}}, half_lane};
      default: load_data = dmem.rdata;
    endcase
  end

  // FSM state register and wait counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= next_state;
      if (cnt_load)
        wait_cnt <= CNT_W'(1);
      else if (cnt_inc)
        wait_cnt <= wait_cnt + 1'b1;
      else if (next_state == IDLE)
        wait_cnt <= '0;
    end
  end

  // Next-state logic and handshake decisions. The abort cycle does not
  // stall, so the timed-out instruction retires as a bubble.
  always_comb begin
    next_state = state;
    req_raw    = 1'b0;
    stall_raw  = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    cnt_load   = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      IDLE: begin
        if (op && !misalign) begin
          req_raw = 1'b1;
          if (dmem.ready) begin
            complete = 1'b1;
          end else begin
            next_state = WAIT;
            stall_raw  = 1'b1;
            cnt_load   = 1'b1;
          end
        end
      end
      WAIT: begin
        req_raw = 1'b1;
        if (dmem.ready) begin
          complete   = 1'b1;
          next_state = IDLE;
        end else if (wait_cnt == TIMEOUT_CNT) begin
          abort      = 1'b1;
          next_state = IDLE;
        end else begin
          stall_raw = 1'b1;
          cnt_inc   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Request and stall drop at once while reset is held, even mid-access.
  always_comb begin
    dmem.req   = rst & req_raw;
    dmem.we    = MemWriteEn_EXMEM;
    dmem.addr  = {ALUResult_EXMEM[31:2], 2'b00};
    dmem.wdata = lane_wdata;
    dmem.be    = lane_be;
    stall_mem  = rst & stall_raw;
  end

  // MEM/WB register: retire completed or non-memory instructions, otherwise
  // insert a bubble; error pulses are registered here too.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      writeRegister_MEMWB <= '0;
      WBData_MEMWB        <= '0;
      RegWriteEn_MEMWB    <= 1'b0;
      misalign_err        <= 1'b0;
      bus_err             <= 1'b0;
    end else begin
      misalign_err <= (state == IDLE) & misalign;
      bus_err      <= abort;
      if (complete || (state == IDLE && !op)) begin
        WBData_MEMWB        <= MemtoReg_EXMEM ? load_data : ALUResult_EXMEM;
        RegWriteEn_MEMWB    <= RegWriteEn_EXMEM;
        writeRegister_MEMWB <= writeRegister_EXMEM;
      end else begin
        RegWriteEn_MEMWB <= 1'b0;
      end
    end
  end

endmodule
